onehot_queue_encoder: RTL and testbench

//   Encoder partner to the 16-output decoder: accepts a 16-bit request vector and

---
 rtl/onehot_queue_encoder.sv | 136 +++++++++++++
 tb/tb_onehot_queue_encoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_queue_encoder.sv
// onehot_queue_encoder: serializes a 16-bit request vector into 4-bit indices,
// lowest set bit first, one index per idx handshake. Outputs are registered and
// always reflect the pending-bit register loaded on the same edge.
module onehot_queue_encoder #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N-1:0]     req_vec,
  input  logic             flush,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [IDX_W-1:0] idx,
  output logic             idx_last,
  output logic             zero_vec,
  output logic             busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [N-1:0] ZERO_VEC = {N{1'b0}};
  localparam logic [N-1:0] ONE_VEC  = {{(N-1){1'b0}}, 1'b1};

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   pend;
  logic [N-1:0]   pend_nxt;
  logic [N-1:0]   pend_clr;
  logic           zero_nxt;
  logic           accept;
  logic           emit;

  // Position of the lowest set bit; zero when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      if (v[k]) begin
        r = IDX_W'(k);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // True when exactly one bit of the vector is set.
  function automatic logic is_onehot(input logic [N-1:0] v);
    return (v != ZERO_VEC) && ((v & (v - ONE_VEC)) == ZERO_VEC);
  endfunction

  // A new vector may enter while idle, or on the final beat of a drain that is
  // not being aborted, which lets back-to-back vectors stream without a bubble.
  assign req_ready = (state == IDLE) |
                     ((state == DRAIN) & idx_ready & idx_last & ~flush);
  assign accept    = req_valid & req_ready;
  assign emit      = idx_valid & idx_ready;
  assign pend_clr  = pend & (pend - ONE_VEC);

  // Next-state and next-pend computation; flush wins over emit and accept in DRAIN.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    zero_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_vec != ZERO_VEC) begin
            pend_nxt  = req_vec;
            state_nxt = DRAIN;
          end else begin
            zero_nxt  = 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (flush) begin
          pend_nxt  = ZERO_VEC;
          state_nxt = IDLE;
        end else if (emit) begin
          if (idx_last) begin
            if (accept && (req_vec != ZERO_VEC)) begin
              pend_nxt  = req_vec;
              state_nxt = DRAIN;
            end else if (accept) begin
              pend_nxt  = ZERO_VEC;
              state_nxt = IDLE;
              zero_nxt  = 1'b1;
            end else begin
              pend_nxt  = ZERO_VEC;
              state_nxt = IDLE;
            end
          end else begin
            pend_nxt  = pend_clr;
          end
        end else begin
          pend_nxt  = pend;
        end
      end
      default: begin
        pend_nxt  = ZERO_VEC;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, pending bits and registered outputs derived from the next pend value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend      <= ZERO_VEC;
      idx_valid <= 1'b0;
      idx       <= {IDX_W{1'b0}};
      idx_last  <= 1'b0;
      zero_vec  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pend      <= pend_nxt;
      idx_valid <= (state_nxt == DRAIN);
      idx       <= lowest_idx(pend_nxt);
      idx_last  <= is_onehot(pend_nxt);
      zero_vec  <= zero_nxt;
      busy      <= (state_nxt == DRAIN);
    end
  end

endmodule

// File: tb/tb_onehot_queue_encoder.sv
// Directed testbench for onehot_queue_encoder: each task drives one scenario
// and checks outputs one time unit after the rising edge.
module tb_onehot_queue_encoder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_vec;
  logic        flush;
  logic        idx_valid;
  logic        idx_ready;
  logic [3:0]  idx;
  logic        idx_last;
  logic        zero_vec;
  logic        busy;

  int checks;
  int errors;

  onehot_queue_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vec   (req_vec),
    .flush     (flush),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .idx       (idx),
    .idx_last  (idx_last),
    .zero_vec  (zero_vec),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_vec = 16'h0000; flush = 1'b0; idx_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (idx_valid !== 1'b0 || idx !== 4'd0 || zero_vec !== 1'b0 || busy !== 1'b0 ||
        req_ready !== 1'b1 || idx_last !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b idx=%0d zero=%b busy=%b ready=%b last=%b, want 0 0 0 0 1 0",
               idx_valid, idx, zero_vec, busy, req_ready, idx_last);
    end
  endtask

  task automatic test_basic();
    logic [3:0] exp_idx [3];
    exp_idx[0] = 4'd0; exp_idx[1] = 4'd4; exp_idx[2] = 4'd15;
    req_valid = 1'b1; req_vec = 16'h8011; idx_ready = 1'b1;
    tick();
    req_valid = 1'b0; req_vec = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (idx_valid !== 1'b1 || idx !== exp_idx[i] || idx_last !== (i == 2) || busy !== 1'b1) begin
        errors++;
        $display("FAIL basic beat %0d: valid=%b idx=%0d last=%b busy=%b, want 1 %0d %b 1",
                 i, idx_valid, idx, idx_last, busy, exp_idx[i], (i == 2));
      end
      tick();
    end
    checks++;
    if (idx_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic idle: valid=%b busy=%b ready=%b, want 0 0 1", idx_valid, busy, req_ready);
    end
  endtask

  task automatic test_backpressure();
    req_valid = 1'b1; req_vec = 16'h0048; idx_ready = 1'b0;
    tick();
    req_valid = 1'b0; req_vec = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (idx_valid !== 1'b1 || idx !== 4'd3 || idx_last !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: valid=%b idx=%0d last=%b, want 1 3 0", i, idx_valid, idx, idx_last);
      end
      if (i < 4) tick();
    end
    idx_ready = 1'b1;
    tick();
    checks++;
    if (idx_valid !== 1'b1 || idx !== 4'd6 || idx_last !== 1'b1) begin
      errors++;
      $display("FAIL bp second: valid=%b idx=%0d last=%b, want 1 6 1", idx_valid, idx, idx_last);
    end
    tick();
    checks++;
    if (idx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp idle: valid=%b busy=%b, want 0 0", idx_valid, busy);
    end
  endtask

  task automatic test_full_vector();
    int bad;
    bad = 0;
    req_valid = 1'b1; req_vec = 16'hFFFF; idx_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (idx_valid !== 1'b1 || idx !== 4'(i) || idx_last !== (i == 15)) begin
        errors++;
        $display("FAIL full beat %0d: valid=%b idx=%0d last=%b, want 1 %0d %b",
                 i, idx_valid, idx, idx_last, i, (i == 15));
      end
      tick();
    end
    checks++;
    if (idx_valid !== 1'b0) begin
      errors++;
      $display("FAIL full idle: valid=%b, want 0", idx_valid);
    end
  endtask

  task automatic test_zero_vector();
    req_valid = 1'b1; req_vec = 16'h0000; idx_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++;
    if (zero_vec !== 1'b1 || idx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero pulse: zero=%b valid=%b busy=%b, want 1 0 0", zero_vec, idx_valid, busy);
    end
    tick();
    checks++;
    if (zero_vec !== 1'b0 || idx_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero after: zero=%b valid=%b, want 0 0", zero_vec, idx_valid);
    end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_vec = 16'h0001; idx_ready = 1'b1;
    tick();
    req_vec = 16'h8000;
    #1;
    checks++;
    if (idx_valid !== 1'b1 || idx !== 4'd0 || idx_last !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b first: valid=%b idx=%0d last=%b ready=%b, want 1 0 1 1",
               idx_valid, idx, idx_last, req_ready);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (idx_valid !== 1'b1 || idx !== 4'd15 || idx_last !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b second: valid=%b idx=%0d last=%b busy=%b, want 1 15 1 1",
               idx_valid, idx, idx_last, busy);
    end
    tick();
    checks++;
    if (idx_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle: valid=%b, want 0", idx_valid);
    end
  endtask

  task automatic test_abort(input logic use_rst);
    req_valid = 1'b1; req_vec = 16'h00F0; idx_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++;
    if (idx_valid !== 1'b1 || idx !== 4'd4) begin
      errors++;
      $display("FAIL abort pre (rst=%b): valid=%b idx=%0d, want 1 4", use_rst, idx_valid, idx);
    end
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    req_valid = 1'b1; req_vec = 16'h0F00;
    #1;
    if (!use_rst) begin
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL flush ready: ready=%b, want 0", req_ready);
      end
    end
    tick();
    rst = 1'b0; flush = 1'b0; req_valid = 1'b0;
    #1;
    checks++;
    if (idx_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || idx !== 4'd0) begin
      errors++;
      $display("FAIL abort post (rst=%b): valid=%b busy=%b ready=%b idx=%0d, want 0 0 1 0",
               use_rst, idx_valid, busy, req_ready, idx);
    end
    tick();
    checks++;
    if (idx_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort stays idle (rst=%b): valid=%b, want 0", use_rst, idx_valid);
    end
  endtask

  task automatic test_flush_idle();
    flush = 1'b1; req_valid = 1'b1; req_vec = 16'h0002; idx_ready = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    checks++;
    if (idx_valid !== 1'b1 || idx !== 4'd1 || idx_last !== 1'b1) begin
      errors++;
      $display("FAIL flush idle accept: valid=%b idx=%0d last=%b, want 1 1 1", idx_valid, idx, idx_last);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_full_vector();
    test_zero_vector();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    test_flush_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
